// File: rtl/iob_sync_debounce_pkg.sv
// iob_sync_debounce_pkg: shared constants and helpers for the input conditioner.
// Provides the counter-width function and the minimum legal parameter values
// used by the per-channel elaboration checks.
package iob_sync_debounce_pkg;

   // Smallest synchroniser depth that still gives metastability protection.
   localparam int IOB_SD_MIN_STAGES     = 2;
   // Smallest stability count: one cycle means "accept on first sight".
   localparam int IOB_SD_MIN_STABLE_CNT = 1;

   // Ceiling log2; returns 0 for values <= 1.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/iob_sync_debounce_ch.sv
// iob_sync_debounce_ch: one channel of the input conditioner.
// Latency: STAGES+STABLE_CNT enabled edges (STAGES+1 without the filter).
// Backpressure: none; cke=0 freezes the channel and clears its pulses.
//
// Ports: clk, rst (async active-high), cke (clock enable), signal_in (async
// level), signal_out (filtered level), rise_o/fall_o (one-cycle edge pulses).
// The stability filter is built only when IOB_SYNC_DEBOUNCE_FILTER_EN is
// defined; otherwise the output follows the synchroniser directly.
module iob_sync_debounce_ch
   import iob_sync_debounce_pkg::*;
#(
   parameter int   STAGES     = 2,
   parameter int   STABLE_CNT = 4,
   parameter logic RST_VAL    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic cke,
   input  logic signal_in,
   output logic signal_out,
   output logic rise_o,
   output logic fall_o
);

   if (STAGES < IOB_SD_MIN_STAGES) begin : g_bad_stages
      $error("iob_sync_debounce_ch: STAGES must be >= %0d", IOB_SD_MIN_STAGES);
   end
   if (STABLE_CNT < IOB_SD_MIN_STABLE_CNT) begin : g_bad_cnt
      $error("iob_sync_debounce_ch: STABLE_CNT must be >= %0d", IOB_SD_MIN_STABLE_CNT);
   end

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              out_q;
   logic              out_d;
   logic              rise_q;
   logic              fall_q;
   logic              s;
   logic              update;

   // Last synchroniser stage is the first value safe to use in this domain.
   assign s      = sync_q[STAGES-1];
   assign sync_d = {sync_q[STAGES-2:0], signal_in};

`ifdef IOB_SYNC_DEBOUNCE_FILTER_EN
   localparam int               CNT_W    = clog2(STABLE_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Count consecutive cycles that s disagrees with the output; any
   // agreement restarts the count, so short glitches never reach the output.
   always_comb begin
      cnt_d  = cnt_q;
      update = 1'b0;
      if (s == out_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         update = 1'b1;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (cke) begin
         cnt_q <= cnt_d;
      end
   end
`else
   // Unfiltered: every change of the synchronised value is taken at once.
   assign update = (s != out_q);
`endif

   assign out_d = update ? s : out_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {STAGES{RST_VAL}};
         out_q  <= RST_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         // Pulses are rewritten every edge so a disabled edge clears them.
         rise_q <= cke & update & s;
         fall_q <= cke & update & ~s;
         if (cke) begin
            sync_q <= sync_d;
            out_q  <= out_d;
         end
      end
   end

   assign signal_out = out_q;
   assign rise_o     = rise_q;
   assign fall_o     = fall_q;

endmodule

// File: rtl/iob_sync_debounce.sv
// iob_sync_debounce: WIDTH-channel synchroniser + debouncer with edge pulses.
// Latency: STAGES+STABLE_CNT enabled edges (STAGES+1 without the filter).
// Backpressure: none; cke=0 freezes all channels and clears their pulses.
//
// Ports: clk, rst (async active-high), cke, signal_in[WIDTH] (async levels),
// signal_out[WIDTH], rise_o[WIDTH], fall_o[WIDTH], changed_o (any pulse).
// Build option: define IOB_SYNC_DEBOUNCE_FILTER_EN to enable the filter.
module iob_sync_debounce
   import iob_sync_debounce_pkg::*;
#(
   parameter int               WIDTH      = 1,
   parameter int               STAGES     = 2,
   parameter logic [WIDTH-1:0] RST_VAL    = '0,
   parameter int               STABLE_CNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cke,
   input  logic [WIDTH-1:0] signal_in,
   output logic [WIDTH-1:0] signal_out,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   output logic             changed_o
);

   for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      iob_sync_debounce_ch #(
         .STAGES     (STAGES),
         .STABLE_CNT (STABLE_CNT),
         .RST_VAL    (RST_VAL[g])
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .cke        (cke),
         .signal_in  (signal_in[g]),
         .signal_out (signal_out[g]),
         .rise_o     (rise_o[g]),
         .fall_o     (fall_o[g])
      );
   end

   // Derived from registered pulses, so it is glitch-free within the cycle.
   assign changed_o = |(rise_o | fall_o);

endmodule

// File: tb/tb_iob_sync_debounce.sv
// tb_iob_sync_debounce: directed bench for the 4-channel input conditioner.
// Expected latencies follow the build: filter on -> 6 edges, off -> 3 edges.
module tb_iob_sync_debounce;

`ifdef IOB_SYNC_DEBOUNCE_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif
   localparam int STAGES = 2;
   localparam int STABLE = 4;
   localparam int LAT    = FILT ? (STAGES + STABLE) : (STAGES + 1);

   logic       clk = 1'b0;
   logic       rst;
   logic       cke;
   logic [3:0] signal_in;
   logic [3:0] signal_out;
   logic [3:0] rise_o;
   logic [3:0] fall_o;
   logic       changed_o;

   int checks   = 0;
   int failures = 0;

   iob_sync_debounce #(
      .WIDTH      (4),
      .STAGES     (STAGES),
      .RST_VAL    (4'h0),
      .STABLE_CNT (STABLE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cke        (cke),
      .signal_in  (signal_in),
      .signal_out (signal_out),
      .rise_o     (rise_o),
      .fall_o     (fall_o),
      .changed_o  (changed_o)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Runs n edges, counting pulses on channel b and noting the first edge
   // index (1-based, -1 if none) of each pulse kind.
   task automatic watch(input int n, input int b, output int nr, output int nf,
                        output int fr, output int ff);
      nr = 0; nf = 0; fr = -1; ff = -1;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk);
         #1;
         if (rise_o[b] === 1'b1) begin
            nr++;
            if (fr < 0) fr = i;
         end
         if (fall_o[b] === 1'b1) begin
            nf++;
            if (ff < 0) ff = i;
         end
      end
   endtask

   initial begin
      int nr, nf, fr, ff, nr2, nf2, fr2, ff2;

      // Reset with all inputs high, then release.
      rst = 1'b1; cke = 1'b1; signal_in = 4'hF;
      step(3);
      check("rst_out", signal_out, 4'h0);
      check("rst_rise", rise_o, 4'h0);
      check("rst_fall", fall_o, 4'h0);
      check("rst_chg", 4'(changed_o), 4'h0);
      rst = 1'b0;
      step(LAT - 1);
      check("rel_out_early", signal_out, 4'h0);
      check("rel_rise_early", rise_o, 4'h0);
      step(1);
      check("rel_out", signal_out, 4'hF);
      check("rel_rise", rise_o, 4'hF);
      check("rel_chg", 4'(changed_o), 4'h1);
      step(1);
      check("rel_rise_once", rise_o, 4'h0);
      check("rel_out_hold", signal_out, 4'hF);
      check("rel_chg_once", 4'(changed_o), 4'h0);

      // Settle all channels low.
      signal_in = 4'h0;
      step(LAT + 2);
      check("settle_out", signal_out, 4'h0);
      check("settle_fall", fall_o, 4'h0);

      // 3-cycle glitch on bit0: rejected by the filter.
      signal_in[0] = 1'b1;
      watch(3, 0, nr, nf, fr, ff);
      signal_in[0] = 1'b0;
      watch(14, 0, nr2, nf2, fr2, ff2);
      check_int("glitch3_rise", nr + nr2, FILT ? 0 : 1);
      check_int("glitch3_fall", nf + nf2, FILT ? 0 : 1);
      check("glitch3_out", signal_out, 4'h0);

      // 4-cycle pulse on bit0: exactly long enough to pass.
      signal_in[0] = 1'b1;
      watch(4, 0, nr, nf, fr, ff);
      signal_in[0] = 1'b0;
      watch(14, 0, nr2, nf2, fr2, ff2);
      check_int("pulse4_rise", nr + nr2, 1);
      check_int("pulse4_fall", nf + nf2, 1);

      // 1-cycle pulse on bit0: follows through only with the filter off.
      signal_in[0] = 1'b1;
      step(1);
      signal_in[0] = 1'b0;
      step(2);
      check("p1_e3_out", signal_out, FILT ? 4'h0 : 4'h1);
      check("p1_e3_rise", rise_o, FILT ? 4'h0 : 4'h1);
      check("p1_e3_fall", fall_o, 4'h0);
      step(1);
      check("p1_e4_out", signal_out, 4'h0);
      check("p1_e4_rise", rise_o, 4'h0);
      check("p1_e4_fall", fall_o, FILT ? 4'h0 : 4'h1);
      step(1);
      check("p1_e5_fall", fall_o, 4'h0);

      // Bounce on bit1 from a settled 1: 0,1,0,0,1 then held 0.
      signal_in = 4'h2;
      step(LAT + 2);
      check("bnc_pre_out", signal_out, 4'h2);
      nf2 = 0;
      signal_in[1] = 1'b0; watch(1, 1, nr, nf, fr, ff); nf2 += nf;
      signal_in[1] = 1'b1; watch(1, 1, nr, nf, fr, ff); nf2 += nf;
      signal_in[1] = 1'b0; watch(1, 1, nr, nf, fr, ff); nf2 += nf;
      signal_in[1] = 1'b0; watch(1, 1, nr, nf, fr, ff); nf2 += nf;
      signal_in[1] = 1'b1; watch(1, 1, nr, nf, fr, ff); nf2 += nf;
      check_int("bnc_seq_fall", nf2, FILT ? 0 : 2);
      signal_in[1] = 1'b0;
      watch(12, 1, nr, nf, fr, ff);
      check_int("bnc_post_fall", nf, 1);
      check_int("bnc_post_fall_edge", ff, LAT);
      check_int("bnc_post_rise", nr, FILT ? 0 : 1);
      check("bnc_out", signal_out, 4'h0);

      // Clock enable held low mid-count on bit2.
      signal_in = 4'h4;
      step(FILT ? 4 : 1);
      cke = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("cke_lo_out", signal_out, 4'h0);
         check("cke_lo_rise", rise_o, 4'h0);
      end
      cke = 1'b1;
      step(1);
      check("cke_e1_out", signal_out, 4'h0);
      step(1);
      check("cke_e2_out", signal_out, 4'h4);
      check("cke_e2_rise", rise_o, 4'h4);
      check("cke_e2_chg", 4'(changed_o), 4'h1);
      cke = 1'b0;
      step(1);
      check("cke_clr_rise", rise_o, 4'h0);
      check("cke_clr_out", signal_out, 4'h4);
      check("cke_clr_chg", 4'(changed_o), 4'h0);
      step(1);
      cke = 1'b1;
      step(1);
      check("cke_no_repulse", rise_o, 4'h0);

      // Reset mid-count on bit3, input returned to 0 during reset.
      signal_in = 4'hC;
      step(FILT ? 4 : 2);
      rst = 1'b1;
      #1;
      check("mid_rst_out", signal_out, 4'h0);
      check("mid_rst_rise", rise_o, 4'h0);
      signal_in = 4'h0;
      step(2);
      rst = 1'b0;
      watch(12, 3, nr, nf, fr, ff);
      check_int("mid_rst_quiet_rise", nr, 0);
      check_int("mid_rst_quiet_fall", nf, 0);
      check("mid_rst_quiet_out", signal_out, 4'h0);

      // Reset mid-count with the input still differing afterwards.
      signal_in = 4'h8;
      step(FILT ? 4 : 2);
      rst = 1'b1;
      #1;
      check("mid_rst2_out", signal_out, 4'h0);
      step(1);
      rst = 1'b0;
      watch(LAT + 3, 3, nr, nf, fr, ff);
      check_int("mid_rst2_rise", nr, 1);
      check_int("mid_rst2_rise_edge", fr, LAT);
      check_int("mid_rst2_fall", nf, 0);
      check("mid_rst2_out_final", signal_out, 4'h8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iob_sync_debounce.md
# iob_sync_debounce

Multi-bit input conditioner: each of WIDTH independent channels passes through a STAGES-deep synchroniser, then an optional stability filter (debouncer), and produces a registered level plus one-cycle rise/fall pulses. It sits at the boundary between asynchronous pins or foreign-domain levels (buttons, status lines, interrupt requests) and the clk domain logic that consumes clean edges.

## Interface
- WIDTH, 1: number of independent channels (≥1).
- STAGES, 2: synchroniser flop count per channel (≥2).
- RST_VAL, 0: reset value of every synchroniser stage and of signal_out, bit per channel.
- STABLE_CNT, 4: consecutive enabled cycles a new synchronised value must hold before signal_out takes it (≥1).
- clk  in  1  clock. Reset rst, asynchronous, active-high; clock clk.
- rst  in  1  asynchronous active-high reset.
- cke  in  1  clock enable; low freezes all state.
- signal_in  in  WIDTH  asynchronous input levels.
- signal_out  out  WIDTH  filtered, synchronised levels.
- rise_o  out  WIDTH  one-cycle pulse per channel, signal_out 0→1.
- fall_o  out  WIDTH  one-cycle pulse per channel, signal_out 1→0.
- changed_o  out  1  OR-reduction of rise_o | fall_o (combinational from registered pulses).

## Operation
- Per channel: sync chain s[0..STAGES-1] shifts signal_in in when cke=1; s = last stage.
- Filter counter cnt, width clog2(STABLE_CNT+1), per channel.
- Each enabled edge: if s == signal_out, cnt←0. Else if cnt == STABLE_CNT-1, signal_out←s, cnt←0, pulse armed. Else cnt←cnt+1.
- Any return of s to signal_out before the count completes clears cnt: glitches shorter than STABLE_CNT cycles are discarded; bouncing restarts the count.
- rise_o ← cke & update & s; fall_o ← cke & update & ~s. Pulses are high exactly in the cycle signal_out first shows the new value; never two consecutive cycles.
- cke=0: sync chain, cnt and signal_out hold; rise_o/fall_o clear to 0 on that edge.
- Channels are fully independent; simultaneous updates on several channels pulse together.
- Reset values: sync stages and signal_out = RST_VAL; cnt = 0; rise_o = fall_o = 0; changed_o = 0.
- After reset, an input differing from RST_VAL goes through the normal path and produces an edge pulse.

## Timing
- Input change sampled at edge 1 (cke held high): s changes at edge STAGES, signal_out and pulse at edge STAGES+STABLE_CNT.
- Filter off (see Configuration): signal_out at edge STAGES+1.
- Cycles with cke=0 add to latency one-for-one; they do not count toward STABLE_CNT.
- rst assertion clears all state immediately, mid-count included; no pulse is emitted by reset or its release.

## Configuration
- IOB_SYNC_DEBOUNCE_FILTER_EN defined: filter counters present, behaviour as above.
- Not defined: no counters; signal_out ← s every enabled edge; pulses on every change of s; STABLE_CNT ignored. Ports unchanged.

## Structure
- Shared package: counter-width function clog2, minimum legal STAGES (2) and STABLE_CNT (1) constants, used for elaboration checks.
- One sub-module: iob_sync_debounce_ch (single channel: sync chain, counter, output/pulse regs), generated WIDTH times; top holds only the generate loop and changed_o reduction.

## Test plan
Defaults WIDTH=4, STAGES=2, STABLE_CNT=4, RST_VAL=0, filter enabled, cke=1 unless stated.
- Reset then release with signal_in=4'hF held -> outputs 0 during rst; signal_out=4'hF at edge 6, rise_o=4'hF for that one cycle only, changed_o=1 same cycle.
- Glitch: bit0 high for 3 cycles then low -> signal_out[0] stays 0, no rise_o/fall_o.
- Bounce: bit1 from 1: 0,1,0,0,1,0 then held 0 -> exactly one fall_o[1] pulse, at edge 6 after the last transition.
- cke low for 5 cycles after 2 counted cycles of a change on bit2 -> no update while low; signal_out[2] updates 2 enabled cycles after cke returns; rise_o cleared while cke=0.
- rst asserted mid-count on bit3 -> signal_out=0, cnt=0 immediately; after release no pulse unless input still differs, then full 6-edge latency.
- Filter macro undefined: bit0 pulse of 1 cycle on signal_in -> signal_out[0] high 1 cycle at edge 3, rise_o then fall_o in consecutive cycles.
